// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, reads instruction memory
//            over a req/ready handshake and hands one instruction at a time to
//            decode over a valid/stall handshake. Next PC (PC+4, branch, jump)
//            is formed here. Optional consumed-instruction counter is enabled
//            by defining FETCH_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump_taken,
    input  logic [25:0] jump_index
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam logic [31:0] c_RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        inst_valid_q;
    logic [31:0] inst_out_q;
    logic [31:0] inst_pc_q;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic        w_consume;

    assign w_pc_plus4   = inst_pc_q + 32'd4;
    assign w_branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign w_consume    = (state_q == ST_HOLD) && !stall;

    // Jump outranks branch when decode raises both.
    always_comb begin
        pc_d = w_pc_plus4;
        if (jump_taken) begin
            pc_d = {w_pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            pc_d = w_pc_plus4 + w_branch_off;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
        end else if (w_consume) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_START;
            pc_q         <= c_RESET_PC_ALIGNED;
            inst_valid_q <= 1'b0;
            inst_out_q   <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_START: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        inst_out_q   <= imem_rdata;
                        inst_pc_q    <= pc_q;
                        inst_valid_q <= 1'b1;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_consume) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= pc_d;
                        state_q      <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_START;
                end
            endcase
        end
    end

    // Request lines decode straight from state so an async reset drops them at once.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;

endmodule

`default_nettype wire
